boss_sprite_engine: RTL and testbench
=====================================

// Module: boss_sprite_engine
// PURPOSE
//  Parametrised sprite renderer for the boss and other large characters on the VGA pixel path.
//  - Reads a texel ROM with integer upscaling and animation frames; drops a transparent key colour.
//  - Bounces the sprite horizontally between two limits; supports a hit-flash effect.
//  - Sits between the VGA timing generator and the colour mux; outputs are delayed 2 clocks vs the pixel coords.
// PARAMETERS
//  COL_W       12      width of display_col / x position
//  ROW_W       11      width of display_row / y position
//  TEX_W_LOG2  6       log2 texels per sprite row (64)
//  TEX_H_LOG2  6       log2 texel rows per sprite (64)
//  SCALE_LOG2  2       log2 screen pixels per texel, both axes (x4)
//  FRAMES_LOG2 2       log2 animation frames stored in ROM (4)
//  KEY         12'hC0F transparent colour, {B,G,R} nibble order
//  BASE_Y      560     fixed top row of sprite
//  X_MIN       0       left bounce limit (inclusive)
//  X_MAX       1023    right bounce limit (inclusive) for the sprite's left edge
//  STEP        2       pixels moved per frame_tick
//  ANIM_DIV    8       frame_ticks per animation frame advance
//  FLASH_LEN   16      frame_ticks a hit flash lasts
// PORTS
//  clock        in   1      pixel clock
//  reset        in   1      asynchronous, active-low reset
//  visible      in   1      active video region
//  display_col  in   COL_W  current pixel column
//  display_row  in   ROW_W  current pixel row
//  frame_tick   in   1      one-clock pulse per frame, during vertical blank
//  move_en      in   1      1 = motion and animation advance on frame_tick
//  hit          in   1      one-clock pulse: start/restart hit flash
//  rom_addr     out  FRAMES_LOG2+TEX_H_LOG2+TEX_W_LOG2  texel address {frame,ty,tx}
//  rom_data     in   12     texel, registered ROM, 1-clock read latency, {B,G,R}
//  spr_red      out  4      pixel red
//  spr_green    out  4      pixel green
//  spr_blue     out  4      pixel blue
//  spr_visible  out  1      1 = sprite owns this pixel
//  pos_x        out  COL_W  current left-edge column (for collision logic)
//  flash_active out  1      hit flash in progress
// BEHAVIOUR
//  Reset (async, reset=0): outputs are spr_* RGB=4'hF, spr_visible=0, pos_x=X_MIN, flash_active=0;
//    also dir=right, frame=0, counters=0, pipeline valids=0. Takes effect mid-line with no partial pixel.
//  Pipeline, stage 0 (cycle of coords):
//    dx = display_col - pos_x, dy = display_row - BASE_Y, both computed 1 bit wider.
//    in_win = visible & dx,dy non-negative & dx < 2^(TEX_W_LOG2+SCALE_LOG2) & dy < 2^(TEX_H_LOG2+SCALE_LOG2).
//    Window is inclusive at the left/top edge and exclusive at the right/bottom edge.
//    rom_addr <= {frame, dy>>SCALE_LOG2, dx>>SCALE_LOG2} (registered); in_win is registered alongside.
//  Stage 1: rom_data valid, paired with the stage-0 registered in_win.
//  Stage 2 (outputs registered):
//    if in_win & rom_data!=KEY: spr_visible=1, RGB = flash_white ? 4'hF each : rom_data nibbles.
//    otherwise: spr_visible=0, RGB=4'hF each.
//    Total latency: coords -> outputs = 2 clocks, fixed, including when visible=0.
//  Flash: flash_white = flash_active & flash_cnt[1]; blinks every 2 frame_ticks.
//  Frame update, only on frame_tick (never mid-frame, so no tearing):
//    if move_en: nx = pos_x +/- STEP per dir.
//      Right and nx>X_MAX: pos_x=X_MAX, dir=left. Left and nx<X_MIN (check borrow): pos_x=X_MIN, dir=right.
//      anim_cnt increments; at ANIM_DIV-1 -> 0 and frame increments, wrapping 2^FRAMES_LOG2-1 -> 0.
//    if flash_active: flash_cnt increments; at FLASH_LEN-1 -> flash_active=0.
//      The flash counter runs regardless of move_en.
//  hit: flash_active=1, flash_cnt=0. A hit during a flash restarts it.
//    hit with frame_tick in the same clock: hit wins, flash_cnt=0.
//  move_en=0 freezes pos_x, dir and frame; rendering continues.
// STRUCTURE
//  Package boss_gfx_pkg: KEY_COLOUR, RGB nibble slice constants, rom address width function.
//  Sub-module boss_motion_ctrl: pos_x/dir/anim/flash counters, frame_tick domain logic.
//  Top level: window compare, 2-stage pixel pipeline, output registers.
// TESTING
//  1. reset=0 mid-line -> next clock spr_visible=0, RGB=FFF, pos_x=0; release -> first sprite pixel at col 0,row 561 after 2 clocks.
//  2. pos_x=100, col 99/100/355/356 on row 600 -> spr_visible 0/1/1/0 (2-clock delayed); rom_addr tx 0 at col 100..103, tx 63 at 352..355.
//  3. ROM texel = 12'hC0F inside window -> spr_visible=0, RGB=FFF; texel 12'h123 -> R=3,G=2,B=1.
//  4. pos_x=1022, STEP=2, dir right, frame_tick -> pos_x=1023, dir left; next tick -> 1021.
//  5. 8 frame_ticks, ANIM_DIV=8 -> frame 0->1; after 32 ticks frame wraps 3->0 and rom_addr MSBs follow.
//  6. hit then 16 frame_ticks -> flash_active drops on 16th tick; hit on tick 10 -> flash lasts 16 ticks from there.

Source files
------------

// File: rtl/boss_gfx_pkg.sv
// Shared definitions for the boss sprite renderer.
//   KEY_COLOUR   : texel value treated as transparent, {B,G,R} nibble order
//   *_LSB        : nibble positions of the colour channels inside a 12-bit texel
//   dir_t        : horizontal bounce direction, the state of the motion FSM
//   rom_addr_w() : width of the texel ROM address {frame, ty, tx}
package boss_gfx_pkg;

    localparam logic [11:0] KEY_COLOUR = 12'hC0F;

    localparam int NIBBLE_W  = 4;
    localparam int RED_LSB   = 0;
    localparam int GREEN_LSB = 4;
    localparam int BLUE_LSB  = 8;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    function automatic int rom_addr_w(input int frames_log2,
                                      input int tex_h_log2,
                                      input int tex_w_log2);
        return frames_log2 + tex_h_log2 + tex_w_log2;
    endfunction

endpackage

// File: rtl/boss_motion_ctrl.sv
// Frame-rate state of the boss sprite: horizontal bounce, animation frame
// and hit flash. Everything here advances only on frame_tick (or on hit),
// so the picture never changes in the middle of a frame.
// Ports:
//   clock, reset         pixel clock, asynchronous active-low reset
//   frame_tick           one-clock pulse per frame
//   move_en              1 = position and animation advance on frame_tick
//   hit                  start/restart the hit flash (wins over frame_tick)
//   pos_x                left-edge column of the sprite
//   frame                current animation frame
//   flash_active         hit flash in progress
//   flash_white          flash is in its white phase right now
module boss_motion_ctrl
    import boss_gfx_pkg::*;
#(
    parameter int COL_W       = 12,
    parameter int FRAMES_LOG2 = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 1023,
    parameter int STEP        = 2,
    parameter int ANIM_DIV    = 8,
    parameter int FLASH_LEN   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   move_en,
    input  logic                   hit,
    output logic [COL_W-1:0]       pos_x,
    output logic [FRAMES_LOG2-1:0] frame,
    output logic                   flash_active,
    output logic                   flash_white
);

    localparam int ANIM_W  = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;
    // At least two bits: bit 1 drives the blink.
    localparam int FLASH_W = (FLASH_LEN > 4) ? $clog2(FLASH_LEN) : 2;

    // Limits compared two bits wider than pos_x so neither the add nor
    // the subtract can wrap. Moving left underflows exactly when
    // pos_x < X_MIN + STEP, which also covers the borrow out of zero.
    localparam logic [COL_W+1:0] RIGHT_LIMIT = (COL_W+2)'(X_MAX);
    localparam logic [COL_W+1:0] LEFT_LIMIT  = (COL_W+2)'(X_MIN + STEP);
    localparam logic [COL_W+1:0] STEP_WIDE   = (COL_W+2)'(STEP);

    dir_t                   dir, dir_nx;
    logic [COL_W-1:0]       pos_x_nx;
    logic [FRAMES_LOG2-1:0] frame_nx;
    logic [ANIM_W-1:0]      anim_cnt, anim_nx;
    logic [FLASH_W-1:0]     flash_cnt, flash_cnt_nx;
    logic                   flash_active_nx;
    logic [COL_W+1:0]       pos_wide;

    assign pos_wide    = {2'b00, pos_x};
    assign flash_white = flash_active & flash_cnt[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir          <= DIR_RIGHT;
            pos_x        <= COL_W'(X_MIN);
            frame        <= '0;
            anim_cnt     <= '0;
            flash_cnt    <= '0;
            flash_active <= 1'b0;
        end else begin
            dir          <= dir_nx;
            pos_x        <= pos_x_nx;
            frame        <= frame_nx;
            anim_cnt     <= anim_nx;
            flash_cnt    <= flash_cnt_nx;
            flash_active <= flash_active_nx;
        end
    end

    always_comb begin
        dir_nx          = dir;
        pos_x_nx        = pos_x;
        frame_nx        = frame;
        anim_nx         = anim_cnt;
        flash_cnt_nx    = flash_cnt;
        flash_active_nx = flash_active;

        if (frame_tick && move_en) begin
            unique case (dir)
                DIR_RIGHT: begin
                    if (pos_wide + STEP_WIDE > RIGHT_LIMIT) begin
                        pos_x_nx = COL_W'(X_MAX);
                        dir_nx   = DIR_LEFT;
                    end else begin
                        pos_x_nx = pos_x + COL_W'(STEP);
                    end
                end
                DIR_LEFT: begin
                    if (pos_wide < LEFT_LIMIT) begin
                        pos_x_nx = COL_W'(X_MIN);
                        dir_nx   = DIR_RIGHT;
                    end else begin
                        pos_x_nx = pos_x - COL_W'(STEP);
                    end
                end
            endcase

            if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
                anim_nx  = '0;
                frame_nx = frame + 1'b1;
            end else begin
                anim_nx  = anim_cnt + 1'b1;
            end
        end

        // The flash counts frames whether or not the sprite is moving.
        if (hit) begin
            flash_active_nx = 1'b1;
            flash_cnt_nx    = '0;
        end else if (frame_tick && flash_active) begin
            if (flash_cnt == FLASH_W'(FLASH_LEN - 1)) begin
                flash_active_nx = 1'b0;
                flash_cnt_nx    = '0;
            end else begin
                flash_cnt_nx    = flash_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boss_sprite_engine.sv
// Boss sprite renderer on the VGA pixel path. Compares the current pixel
// against the sprite window, fetches the upscaled texel and produces the
// sprite colour two clocks after the coordinates, whether or not the
// pixel is visible.
// Ports:
//   clock, reset                   pixel clock, asynchronous active-low reset
//   visible                        active video region
//   display_col, display_row       current pixel coordinates
//   frame_tick, move_en, hit       frame-rate controls (see boss_motion_ctrl)
//   rom_addr / rom_data            texel ROM {frame,ty,tx}; data valid the
//                                  clock after rom_addr updates
//   spr_red/green/blue, spr_visible  registered sprite pixel
//   pos_x, flash_active            sprite state for collision/effects logic
module boss_sprite_engine
    import boss_gfx_pkg::*;
#(
    parameter int          COL_W       = 12,
    parameter int          ROW_W       = 11,
    parameter int          TEX_W_LOG2  = 6,
    parameter int          TEX_H_LOG2  = 6,
    parameter int          SCALE_LOG2  = 2,
    parameter int          FRAMES_LOG2 = 2,
    parameter logic [11:0] KEY         = KEY_COLOUR,
    parameter int          BASE_Y      = 560,
    parameter int          X_MIN       = 0,
    parameter int          X_MAX       = 1023,
    parameter int          STEP        = 2,
    parameter int          ANIM_DIV    = 8,
    parameter int          FLASH_LEN   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    visible,
    input  logic [COL_W-1:0]        display_col,
    input  logic [ROW_W-1:0]        display_row,
    input  logic                    frame_tick,
    input  logic                    move_en,
    input  logic                    hit,
    output logic [rom_addr_w(FRAMES_LOG2, TEX_H_LOG2, TEX_W_LOG2)-1:0] rom_addr,
    input  logic [11:0]             rom_data,
    output logic [3:0]              spr_red,
    output logic [3:0]              spr_green,
    output logic [3:0]              spr_blue,
    output logic                    spr_visible,
    output logic [COL_W-1:0]        pos_x,
    output logic                    flash_active
);

    localparam int SPAN_X = 1 << (TEX_W_LOG2 + SCALE_LOG2);
    localparam int SPAN_Y = 1 << (TEX_H_LOG2 + SCALE_LOG2);

    logic [FRAMES_LOG2-1:0] frame;
    logic                   flash_white;
    logic [COL_W:0]         dx;
    logic [ROW_W:0]         dy;
    logic                   in_win;
    logic                   in_win_q;

    boss_motion_ctrl #(
        .COL_W       (COL_W),
        .FRAMES_LOG2 (FRAMES_LOG2),
        .X_MIN       (X_MIN),
        .X_MAX       (X_MAX),
        .STEP        (STEP),
        .ANIM_DIV    (ANIM_DIV),
        .FLASH_LEN   (FLASH_LEN)
    ) u_motion (
        .clock        (clock),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .move_en      (move_en),
        .hit          (hit),
        .pos_x        (pos_x),
        .frame        (frame),
        .flash_active (flash_active),
        .flash_white  (flash_white)
    );

    // One extra bit so a pixel left of / above the sprite shows up as a
    // set sign bit instead of wrapping to a large positive offset.
    assign dx = {1'b0, display_col} - {1'b0, pos_x};
    assign dy = {1'b0, display_row} - (ROW_W+1)'(BASE_Y);

    // Inclusive at the left/top edge, exclusive at the right/bottom edge.
    assign in_win = visible
                  && !dx[COL_W] && (dx < (COL_W+1)'(SPAN_X))
                  && !dy[ROW_W] && (dy < (ROW_W+1)'(SPAN_Y));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rom_addr    <= '0;
            in_win_q    <= 1'b0;
            spr_visible <= 1'b0;
            spr_red     <= 4'hF;
            spr_green   <= 4'hF;
            spr_blue    <= 4'hF;
        end else begin
            // Stage 0: texel address and window flag travel together.
            rom_addr <= {frame,
                         dy[SCALE_LOG2 +: TEX_H_LOG2],
                         dx[SCALE_LOG2 +: TEX_W_LOG2]};
            in_win_q <= in_win;

            // Stage 1 -> 2: rom_data belongs to in_win_q.
            if (in_win_q && (rom_data != KEY)) begin
                spr_visible <= 1'b1;
                spr_red     <= flash_white ? 4'hF : rom_data[RED_LSB   +: NIBBLE_W];
                spr_green   <= flash_white ? 4'hF : rom_data[GREEN_LSB +: NIBBLE_W];
                spr_blue    <= flash_white ? 4'hF : rom_data[BLUE_LSB  +: NIBBLE_W];
            end else begin
                spr_visible <= 1'b0;
                spr_red     <= 4'hF;
                spr_green   <= 4'hF;
                spr_blue    <= 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_boss_sprite_engine.sv
// Self-checking bench for boss_sprite_engine with default parameters.
module tb_boss_sprite_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        visible;
    logic [11:0] display_col;
    logic [10:0] display_row;
    logic        frame_tick;
    logic        move_en;
    logic        hit;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  spr_red;
    logic [3:0]  spr_green;
    logic [3:0]  spr_blue;
    logic        spr_visible;
    logic [11:0] pos_x;
    logic        flash_active;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT and texel ROM ----------------
    boss_sprite_engine dut (
        .clock        (clock),
        .reset        (reset),
        .visible      (visible),
        .display_col  (display_col),
        .display_row  (display_row),
        .frame_tick   (frame_tick),
        .move_en      (move_en),
        .hit          (hit),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .spr_red      (spr_red),
        .spr_green    (spr_green),
        .spr_blue     (spr_blue),
        .spr_visible  (spr_visible),
        .pos_x        (pos_x),
        .flash_active (flash_active)
    );

    logic [11:0] rom_mem [0:16383];
    assign rom_data = rom_mem[rom_addr];

    // ---------------- reference model state ----------------
    int m_pos;
    int m_frame;
    int m_anim;
    int m_fc;
    bit m_dir_right;
    bit m_fa;

    task automatic model_reset();
        m_pos = 0; m_frame = 0; m_anim = 0; m_fc = 0;
        m_dir_right = 1'b1; m_fa = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];
    int          due_q[$];
    logic [13:0] aexp_q[$];
    int          adue_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic flush_queues();
        exp_q.delete(); due_q.delete(); aexp_q.delete(); adue_q.delete();
    endtask

    always @(negedge clock) begin
        while (adue_q.size() > 0 && adue_q[0] <= cyc) begin
            check("rom_addr", 32'(rom_addr), 32'(aexp_q.pop_front()));
            void'(adue_q.pop_front());
        end
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            check("pixel", 32'({spr_visible, spr_blue, spr_green, spr_red}),
                  32'(exp_q.pop_front()));
            void'(due_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            visible = 1'b0; frame_tick = 1'b0; hit = 1'b0;
        end
    endtask

    // Drives one pixel and pushes the expected rom_addr (1 clock) and
    // expected output pixel (2 clocks).
    task automatic drive_px(input logic vis, input int col, input int row);
        logic [12:0] e;
        logic [11:0] t;
        int dx, dy, a;
        @(posedge clock); #1;
        visible = vis; display_col = 12'(col); display_row = 11'(row);
        frame_tick = 1'b0; hit = 1'b0;
        dx = col - m_pos;
        dy = row - 560;
        e  = 13'h0FFF;
        if (vis && dx >= 0 && dx < 256 && dy >= 0 && dy < 256) begin
            a = m_frame * 4096 + (dy / 4) * 64 + (dx / 4);
            aexp_q.push_back(14'(a));
            adue_q.push_back(cyc + 1);
            t = rom_mem[a];
            if (t != 12'hC0F) e = {1'b1, (m_fa && m_fc[1]) ? 12'hFFF : t};
        end
        exp_q.push_back(e);
        due_q.push_back(cyc + 2);
    endtask

    // One frame_tick, optionally with hit in the same clock.
    task automatic tick(input logic me, input logic h);
        idle(3);
        @(posedge clock); #1;
        visible = 1'b0; frame_tick = 1'b1; move_en = me; hit = h;
        if (me) begin
            if (m_dir_right) begin
                if (m_pos + 2 > 1023) begin m_pos = 1023; m_dir_right = 1'b0; end
                else m_pos = m_pos + 2;
            end else begin
                if (m_pos - 2 < 0) begin m_pos = 0; m_dir_right = 1'b1; end
                else m_pos = m_pos - 2;
            end
            if (m_anim == 7) begin m_anim = 0; m_frame = (m_frame + 1) % 4; end
            else m_anim = m_anim + 1;
        end
        if (h) begin m_fa = 1'b1; m_fc = 0; end
        else if (m_fa) begin
            if (m_fc == 15) begin m_fa = 1'b0; m_fc = 0; end
            else m_fc = m_fc + 1;
        end
        @(posedge clock); #1;
        frame_tick = 1'b0; hit = 1'b0; move_en = 1'b0;
        check("pos_x", 32'(pos_x), 32'(m_pos));
        check("flash_active", 32'(flash_active), 32'(m_fa));
    endtask

    task automatic hit_pulse();
        idle(3);
        @(posedge clock); #1;
        hit = 1'b1;
        m_fa = 1'b1; m_fc = 0;
        @(posedge clock); #1;
        hit = 1'b0;
        check("flash_after_hit", 32'(flash_active), 32'(m_fa));
    endtask

    task automatic row_sweep(input int row, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) drive_px(1'b1, c, row);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16384; i++) begin
            if (i % 13 == 7) rom_mem[i] = 12'hC0F;
            else rom_mem[i] = 12'((i * 37 + 11) ^ (i >> 5));
        end
        reset = 1'b0; visible = 1'b0; display_col = '0; display_row = '0;
        frame_tick = 1'b0; move_en = 1'b0; hit = 1'b0;
        model_reset();

        // Reset values.
        repeat (3) @(posedge clock);
        #1;
        check("rst_visible", 32'(spr_visible), 32'd0);
        check("rst_rgb", 32'({spr_blue, spr_green, spr_red}), 32'hFFF);
        check("rst_pos_x", 32'(pos_x), 32'd0);
        check("rst_flash", 32'(flash_active), 32'd0);

        // Release; sprite at pos 0, first rows of the window and its edges.
        @(posedge clock); #1; reset = 1'b1;
        row_sweep(561, 0, 7);
        drive_px(1'b1, 0, 560);
        drive_px(1'b1, 0, 559);
        drive_px(1'b1, 255, 600);
        drive_px(1'b1, 256, 600);
        drive_px(1'b1, 10, 815);
        drive_px(1'b1, 10, 816);

        // Move right to pos_x = 100 (animation advances to frame 2).
        for (int i = 0; i < 50; i++) tick(1'b1, 1'b0);
        drive_px(1'b1, 99, 600);
        drive_px(1'b1, 100, 600);
        drive_px(1'b1, 355, 600);
        drive_px(1'b1, 356, 600);
        row_sweep(600, 100, 104);
        row_sweep(600, 351, 355);
        drive_px(1'b0, 200, 600);

        // Transparent key vs explicit colour: ty=10, tx=5/6 in frame 2.
        rom_mem[m_frame * 4096 + 10 * 64 + 5] = 12'hC0F;
        rom_mem[m_frame * 4096 + 10 * 64 + 6] = 12'h123;
        row_sweep(600, 120, 127);

        // Hit flash: normal colours, then white after 2 ticks, drop at tick 16.
        hit_pulse();
        row_sweep(610, 100, 107);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        row_sweep(610, 100, 107);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0);
        row_sweep(610, 100, 103);

        // Restart: hit again, then a hit together with the 10th tick.
        hit_pulse();
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b0);

        // Right bounce: run to 1022, then 1023 / turn left / 1021.
        while (m_pos < 1022) tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        row_sweep(700, 1019, 1026);
        row_sweep(700, 1275, 1280);

        // Left bounce back to X_MIN and turn right again.
        for (int i = 0; i < 600 && m_pos != 0; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        row_sweep(565, 0, 5);

        // Random pixels around the window.
        for (int i = 0; i < 200; i++) begin
            drive_px(1'($urandom_range(0, 3) != 0),
                     m_pos + $urandom_range(0, 300),
                     $urandom_range(540, 830));
        end

        // Mid-line asynchronous reset with the sprite moved and flashing.
        hit_pulse();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        row_sweep(600, 10, 20);
        @(posedge clock); #3;
        reset = 1'b0;
        flush_queues();
        #1;
        check("mid_rst_visible", 32'(spr_visible), 32'd0);
        check("mid_rst_rgb", 32'({spr_blue, spr_green, spr_red}), 32'hFFF);
        check("mid_rst_pos_x", 32'(pos_x), 32'd0);
        check("mid_rst_flash", 32'(flash_active), 32'd0);
        model_reset();
        @(posedge clock); #1;
        check("mid_rst_held", 32'(spr_visible), 32'd0);
        reset = 1'b1;
        row_sweep(561, 0, 3);

        idle(4);
        check("queue_drain", 32'(exp_q.size() + aexp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
